// File: rtl/hazard_detection_unit_if.sv
// Bundle of pipeline-side hazard inputs and buffer control outputs for hazard_detection_unit.
// The slave modport belongs to the unit; the master modport belongs to the pipeline driving it.
interface hazard_detection_unit_if #(
  parameter int REG_W = 4,
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] IF_ID_RegisterOp1;
  logic [REG_W-1:0] IF_ID_RegisterOp2;
  logic             IF_ID_UsesOp1;
  logic             IF_ID_UsesOp2;
  logic [REG_W-1:0] ID_EX_RegisterOp1;
  logic             ID_EX_MemRead;
  logic             ID_EX_MulDiv;
  logic             EX_BranchTaken;

  logic             PC_Write;
  logic             IF_ID_Write;
  logic             IF_ID_Flush;
  logic             ID_EX_Write;
  logic             ID_EX_Bubble;
  logic             EX_MEM_Bubble;
  logic [1:0]       Hazard_State;
  logic [CNT_W-1:0] Stall_Count;

  modport master (
    output IF_ID_RegisterOp1, IF_ID_RegisterOp2, IF_ID_UsesOp1, IF_ID_UsesOp2,
    output ID_EX_RegisterOp1, ID_EX_MemRead, ID_EX_MulDiv, EX_BranchTaken,
    input  PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Bubble,
    input  EX_MEM_Bubble, Hazard_State, Stall_Count
  );

  modport slave (
    input  IF_ID_RegisterOp1, IF_ID_RegisterOp2, IF_ID_UsesOp1, IF_ID_UsesOp2,
    input  ID_EX_RegisterOp1, ID_EX_MemRead, ID_EX_MulDiv, EX_BranchTaken,
    output PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Bubble,
    output EX_MEM_Bubble, Hazard_State, Stall_Count
  );
endinterface

// File: rtl/hazard_detection_unit.sv
// Resolves load-use stalls, multi-cycle MUL/DIV EX freezes and taken-branch flushes by
// driving the pipeline buffer enables and bubble controls; also counts PC stall cycles.
module hazard_detection_unit #(
  parameter int REG_W         = 4,
  parameter int MULDIV_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  hazard_detection_unit_if.slave hif
);

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_MD_BUSY = 2'b01;
  localparam logic [1:0] ST_MD_LAST = 2'b10;

  localparam logic [3:0] CNT_LOAD       = 4'(MULDIV_CYCLES - 2);
  localparam logic [1:0] ST_AFTER_START = (MULDIV_CYCLES > 2) ? ST_MD_BUSY : ST_MD_LAST;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [3:0]       cnt;
  logic [3:0]       cnt_nxt;
  logic [CNT_W-1:0] stall_count;

  logic pc_write;
  logic if_id_write;
  logic if_id_flush;
  logic id_ex_write;
  logic id_ex_bubble;
  logic ex_mem_bubble;
  logic load_use;

  assign load_use = hif.ID_EX_MemRead
                  & (hif.ID_EX_RegisterOp1 != {REG_W{1'b0}})
                  & ((hif.IF_ID_UsesOp1 & (hif.IF_ID_RegisterOp1 == hif.ID_EX_RegisterOp1))
                   | (hif.IF_ID_UsesOp2 & (hif.IF_ID_RegisterOp2 == hif.ID_EX_RegisterOp1)));

  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_write   = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    state_nxt     = state;
    cnt_nxt       = cnt;

    if (rst) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_bubble  = 1'b1;
      ex_mem_bubble = 1'b1;
      state_nxt     = ST_IDLE;
      cnt_nxt       = 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (hif.ID_EX_MulDiv) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_bubble = 1'b1;
            cnt_nxt       = CNT_LOAD;
            state_nxt     = ST_AFTER_START;
          end else if (hif.EX_BranchTaken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
          end
        end

        // cnt holds the busy cycles still owed; leave for MD_LAST as the last one is spent
        ST_MD_BUSY: begin
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          id_ex_write   = 1'b0;
          ex_mem_bubble = 1'b1;
          cnt_nxt       = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
          if (cnt <= 4'd1) begin
            state_nxt = ST_MD_LAST;
          end
        end

        // The finished op is still in EX here, so its MulDiv flag must not retrigger
        ST_MD_LAST: begin
          if (load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
          end
          state_nxt = ST_IDLE;
        end

        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state <= state_nxt;
    cnt   <= cnt_nxt;
    if (rst) begin
      stall_count <= '0;
    end else if (!pc_write && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign hif.PC_Write      = pc_write;
  assign hif.IF_ID_Write   = if_id_write;
  assign hif.IF_ID_Flush   = if_id_flush;
  assign hif.ID_EX_Write   = id_ex_write;
  assign hif.ID_EX_Bubble  = id_ex_bubble;
  assign hif.EX_MEM_Bubble = ex_mem_bubble;
  assign hif.Hazard_State  = state;
  assign hif.Stall_Count   = stall_count;

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Self-checking bench for hazard_detection_unit: directed scenarios with literal expectations
// plus randomized traffic checked against a cycle-position reference model.
module tb_hazard_detection_unit;

  localparam int REG_W = 4;
  localparam int N     = 4;
  localparam int CNT_W = 16;

  // Control vector order: {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Bubble, EX_MEM_Bubble}
  localparam logic [5:0] C_DEF = 6'b110100;
  localparam logic [5:0] C_FRZ = 6'b000001;
  localparam logic [5:0] C_BR  = 6'b111110;
  localparam logic [5:0] C_LU  = 6'b000110;
  localparam logic [5:0] C_RST = 6'b001111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_detection_unit_if #(.REG_W(REG_W), .CNT_W(CNT_W)) hif();

  hazard_detection_unit #(.REG_W(REG_W), .MULDIV_CYCLES(N), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .hif (hif)
  );

  logic [5:0] obs_ctrl;
  assign obs_ctrl = {hif.PC_Write, hif.IF_ID_Write, hif.IF_ID_Flush,
                     hif.ID_EX_Write, hif.ID_EX_Bubble, hif.EX_MEM_Bubble};

  int errors = 0;
  int checks = 0;

  // Reference model: m_pos is the index of the current cycle within a MUL/DIV occupancy (-1 = none)
  int         m_pos   = -1;
  int         m_stall = 0;
  logic [5:0] e_ctrl;
  logic [1:0] e_state;
  logic [15:0] e_stall;

  task automatic drive(input logic r, input logic [3:0] op1, input logic [3:0] op2,
                       input logic u1, input logic u2, input logic [3:0] dest,
                       input logic mr, input logic md, input logic br);
    logic lu;
    @(negedge clk);
    rst                   = r;
    hif.IF_ID_RegisterOp1 = op1;
    hif.IF_ID_RegisterOp2 = op2;
    hif.IF_ID_UsesOp1     = u1;
    hif.IF_ID_UsesOp2     = u2;
    hif.ID_EX_RegisterOp1 = dest;
    hif.ID_EX_MemRead     = mr;
    hif.ID_EX_MulDiv      = md;
    hif.EX_BranchTaken    = br;
    #1;
    lu      = mr && (dest != 0) && ((u1 && op1 == dest) || (u2 && op2 == dest));
    e_stall = m_stall[15:0];
    e_state = (m_pos < 0) ? 2'b00 : (m_pos == N - 1) ? 2'b10 : 2'b01;
    if (r) begin
      e_ctrl  = C_RST;
      m_pos   = -1;
      m_stall = 0;
    end else begin
      if (m_pos >= 1 && m_pos <= N - 2) begin
        e_ctrl = C_FRZ;
        m_pos++;
      end else if (m_pos == N - 1) begin
        e_ctrl = lu ? C_LU : C_DEF;
        m_pos  = -1;
      end else if (md) begin
        e_ctrl = C_FRZ;
        m_pos  = 1;
      end else if (br) begin
        e_ctrl = C_BR;
      end else if (lu) begin
        e_ctrl = C_LU;
      end else begin
        e_ctrl = C_DEF;
      end
      if (!e_ctrl[5] && m_stall < 65535) m_stall++;
    end
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (obs_ctrl !== C_RST) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b expected %b", obs_ctrl, C_RST);
    end
    idle();
    checks++;
    if (hif.Hazard_State !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_state: got %b expected 00", hif.Hazard_State);
    end
    checks++;
    if (hif.Stall_Count !== 16'd0) begin
      errors++;
      $display("[TB] FAIL reset_count: got %0d expected 0", hif.Stall_Count);
    end
    checks++;
    if (obs_ctrl !== C_DEF) begin
      errors++;
      $display("[TB] FAIL reset_default_ctrl: got %b expected %b", obs_ctrl, C_DEF);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    idle();
    drive(1'b0, 4'd7, 4'd3, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs_ctrl !== C_LU) begin
      errors++;
      $display("[TB] FAIL load_use_ctrl: got %b expected %b", obs_ctrl, C_LU);
    end
    idle();
    checks++;
    if (obs_ctrl !== C_DEF) begin
      errors++;
      $display("[TB] FAIL load_use_release: got %b expected %b", obs_ctrl, C_DEF);
    end
    checks++;
    if (hif.Stall_Count !== 16'd1) begin
      errors++;
      $display("[TB] FAIL load_use_count: got %0d expected 1", hif.Stall_Count);
    end
  endtask

  task automatic test_no_stall();
    do_reset();
    idle();
    drive(1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs_ctrl !== C_DEF) begin
      errors++;
      $display("[TB] FAIL no_stall_r0: got %b expected %b", obs_ctrl, C_DEF);
    end
    drive(1'b0, 4'd7, 4'd3, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs_ctrl !== C_DEF) begin
      errors++;
      $display("[TB] FAIL no_stall_unused: got %b expected %b", obs_ctrl, C_DEF);
    end
    idle();
    checks++;
    if (hif.Stall_Count !== 16'd0) begin
      errors++;
      $display("[TB] FAIL no_stall_count: got %0d expected 0", hif.Stall_Count);
    end
  endtask

  task automatic test_muldiv();
    logic [5:0] exp_c [5] = '{C_FRZ, C_FRZ, C_FRZ, C_DEF, C_DEF};
    logic [1:0] exp_s [5] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b00};
    do_reset();
    idle();
    for (int t = 0; t < 5; t++) begin
      drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, (t < 4), 1'b0);
      checks++;
      if (obs_ctrl !== exp_c[t]) begin
        errors++;
        $display("[TB] FAIL muldiv_ctrl t+%0d: got %b expected %b", t, obs_ctrl, exp_c[t]);
      end
      checks++;
      if (hif.Hazard_State !== exp_s[t]) begin
        errors++;
        $display("[TB] FAIL muldiv_state t+%0d: got %b expected %b", t, hif.Hazard_State, exp_s[t]);
      end
    end
    checks++;
    if (hif.Stall_Count !== 16'd3) begin
      errors++;
      $display("[TB] FAIL muldiv_count: got %0d expected 3", hif.Stall_Count);
    end
  endtask

  task automatic test_branch_priority();
    do_reset();
    idle();
    drive(1'b0, 4'd5, 4'd0, 1'b1, 1'b0, 4'd5, 1'b1, 1'b0, 1'b1);
    checks++;
    if (obs_ctrl !== C_BR) begin
      errors++;
      $display("[TB] FAIL branch_ctrl: got %b expected %b", obs_ctrl, C_BR);
    end
    idle();
    checks++;
    if (hif.Stall_Count !== 16'd0) begin
      errors++;
      $display("[TB] FAIL branch_count: got %0d expected 0", hif.Stall_Count);
    end
  endtask

  task automatic test_reset_mid_freeze();
    do_reset();
    idle();
    drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (obs_ctrl !== C_RST) begin
      errors++;
      $display("[TB] FAIL midreset_ctrl: got %b expected %b", obs_ctrl, C_RST);
    end
    idle();
    checks++;
    if (hif.Hazard_State !== 2'b00) begin
      errors++;
      $display("[TB] FAIL midreset_state: got %b expected 00", hif.Hazard_State);
    end
    checks++;
    if (hif.Stall_Count !== 16'd0) begin
      errors++;
      $display("[TB] FAIL midreset_count: got %0d expected 0", hif.Stall_Count);
    end
    checks++;
    if (obs_ctrl !== C_DEF) begin
      errors++;
      $display("[TB] FAIL midreset_default: got %b expected %b", obs_ctrl, C_DEF);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom_range(0, 49) == 0),
            4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0));
      checks++;
      if (obs_ctrl !== e_ctrl) begin
        errors++;
        $display("[TB] FAIL random_ctrl cycle %0d: got %b expected %b", i, obs_ctrl, e_ctrl);
      end
      checks++;
      if (hif.Hazard_State !== e_state) begin
        errors++;
        $display("[TB] FAIL random_state cycle %0d: got %b expected %b", i, hif.Hazard_State, e_state);
      end
      checks++;
      if (hif.Stall_Count !== e_stall) begin
        errors++;
        $display("[TB] FAIL random_count cycle %0d: got %0d expected %0d", i, hif.Stall_Count, e_stall);
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 70000; i++) begin
      drive(1'b0, 4'd0, 4'd3, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0);
      if ((i % 1000) == 0 || i > 65530) begin
        checks++;
        if (hif.Stall_Count !== e_stall) begin
          errors++;
          $display("[TB] FAIL sat_track cycle %0d: got %0d expected %0d", i, hif.Stall_Count, e_stall);
        end
      end
    end
    idle();
    checks++;
    if (hif.Stall_Count !== 16'hFFFF) begin
      errors++;
      $display("[TB] FAIL sat_final: got %h expected ffff", hif.Stall_Count);
    end
  endtask

  initial begin
    hif.IF_ID_RegisterOp1 = '0;
    hif.IF_ID_RegisterOp2 = '0;
    hif.IF_ID_UsesOp1     = 1'b0;
    hif.IF_ID_UsesOp2     = 1'b0;
    hif.ID_EX_RegisterOp1 = '0;
    hif.ID_EX_MemRead     = 1'b0;
    hif.ID_EX_MulDiv      = 1'b0;
    hif.EX_BranchTaken    = 1'b0;
    test_reset();
    test_load_use();
    test_no_stall();
    test_muldiv();
    test_branch_priority();
    test_reset_mid_freeze();
    test_random();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
